// File: rtl/sm_arith_pkg.sv
// sm_arith_pkg: shared constants, op encoding and slice helpers for sign-magnitude arithmetic
package sm_arith_pkg;
    localparam int NW_DEF = 16;
    localparam int SIGN_BIT = NW_DEF;
    localparam logic [NW_DEF:0] SM_ZERO = '0;
    localparam logic [NW_DEF-1:0] MAX_MAG = '1;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    function automatic logic [NW_DEF-1:0] mag_of(input logic [NW_DEF:0] x);
        return x[NW_DEF-1:0];
    endfunction
    function automatic logic sign_of(input logic [NW_DEF:0] x);
        return x[SIGN_BIT];
    endfunction
endpackage

// File: rtl/sm_addsub_pipe_if.sv
// sm_addsub_pipe_if: operation/result handshake bundle; master drives operations, slave is the pipeline
interface sm_addsub_pipe_if
    import sm_arith_pkg::*;
#(
    parameter int NUMWIDTH = NW_DEF,
    parameter int TAG_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [NUMWIDTH:0]   in_a;
    logic [NUMWIDTH:0]   in_b;
    logic                in_sub;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [NUMWIDTH:0]   out_sum;
    logic                out_ovf;
    logic [TAG_W-1:0]    out_tag;
    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_tag
    );
endinterface

// File: rtl/sm_mag_order.sv
// sm_mag_order: orders two magnitudes (big, small) and derives result sign and add/diff kind
module sm_mag_order #(
    parameter int NUMWIDTH = 16
) (
    input  logic [NUMWIDTH-1:0] i_a_mag,
    input  logic [NUMWIDTH-1:0] i_b_mag,
    input  logic                i_a_sgn,
    input  logic                i_b_sgn,
    output logic [NUMWIDTH-1:0] o_big,
    output logic [NUMWIDTH-1:0] o_small,
    output logic                o_sgn,
    output logic                o_is_add
);
    logic w_a_ge;
    // equal magnitudes pick a; a zero difference is normalised downstream
    always_comb begin
        w_a_ge   = i_a_mag >= i_b_mag;
        o_is_add = i_a_sgn == i_b_sgn;
        o_big    = w_a_ge ? i_a_mag : i_b_mag;
        o_small  = w_a_ge ? i_b_mag : i_a_mag;
        o_sgn    = (o_is_add || w_a_ge) ? i_a_sgn : i_b_sgn;
    end
endmodule

// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: 2-stage sign-magnitude add/sub with handshakes; SM_SAT_EN selects saturating overflow
module sm_addsub_pipe
    import sm_arith_pkg::*;
#(
    parameter int NUMWIDTH = NW_DEF,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    sm_addsub_pipe_if.slave    io,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   ovf_cnt
);
    logic                r_s1_valid;
    logic [NUMWIDTH-1:0] r_s1_big;
    logic [NUMWIDTH-1:0] r_s1_small;
    logic                r_s1_sgn;
    logic                r_s1_add;
    logic [TAG_W-1:0]    r_s1_tag;
    logic                r_s2_valid;
    logic [NUMWIDTH:0]   r_out_sum;
    logic                r_out_ovf;
    logic [TAG_W-1:0]    r_out_tag;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic                w_s1_load;
    logic                w_s2_load;
    logic [NUMWIDTH-1:0] w_a_mag;
    logic [NUMWIDTH-1:0] w_b_mag;
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [NUMWIDTH-1:0] w_big;
    logic [NUMWIDTH-1:0] w_small;
    logic                w_sgn;
    logic                w_is_add;
    logic [NUMWIDTH:0]   w_sum;
    logic                w_ovf;
    logic [NUMWIDTH-1:0] w_mag;

    assign w_s2_load   = !r_s2_valid || io.out_ready;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign io.in_ready = w_s1_load;
    assign io.out_valid = r_s2_valid;
    assign io.out_sum  = r_out_sum;
    assign io.out_ovf  = r_out_ovf;
    assign io.out_tag  = r_out_tag;
    assign ovf_cnt     = r_ovf_cnt;

    // effective signs; a zero magnitude always counts as positive
    always_comb begin
        w_a_mag = io.in_a[NUMWIDTH-1:0];
        w_b_mag = io.in_b[NUMWIDTH-1:0];
        w_a_sgn = io.in_a[NUMWIDTH] & (|w_a_mag);
        w_b_sgn = (io.in_b[NUMWIDTH] ^ (op_e'(io.in_sub) == OP_SUB)) & (|w_b_mag);
    end

    sm_mag_order #(.NUMWIDTH(NUMWIDTH)) u_order (
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .i_a_sgn  (w_a_sgn),
        .i_b_sgn  (w_b_sgn),
        .o_big    (w_big),
        .o_small  (w_small),
        .o_sgn    (w_sgn),
        .o_is_add (w_is_add)
    );

    // stage 1: capture ordered operands, result sign, op kind and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= io.in_valid;
            if (io.in_valid) begin
                r_s1_big   <= w_big;
                r_s1_small <= w_small;
                r_s1_sgn   <= w_sgn;
                r_s1_add   <= w_is_add;
                r_s1_tag   <= io.in_tag;
            end
        end
    end

    // magnitude arithmetic with overflow handling; big >= small so the difference never borrows
    always_comb begin
        w_sum = r_s1_add ? ({1'b0, r_s1_big} + {1'b0, r_s1_small}) : {1'b0, r_s1_big - r_s1_small};
        w_ovf = r_s1_add & w_sum[NUMWIDTH];
`ifdef SM_SAT_EN
        w_mag = w_ovf ? {NUMWIDTH{1'b1}} : w_sum[NUMWIDTH-1:0];
`else
        w_mag = w_sum[NUMWIDTH-1:0];
`endif
    end

    // stage 2: result register feeding the outputs, with -0 folded to +0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_sum  <= '0;
            r_out_ovf  <= 1'b0;
            r_out_tag  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sum <= {r_s1_sgn & (|w_mag), w_mag};
                r_out_ovf <= w_ovf;
                r_out_tag <= r_s1_tag;
            end
        end
    end

    // overflow event counter: saturating, clear takes priority over a coincident event
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_ovf_cnt <= '0;
        end else if (r_s2_valid && io.out_ready && r_out_ovf && !(&r_ovf_cnt)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// tb_sm_addsub_pipe: directed and randomized checks of sm_addsub_pipe against an integer reference model
module tb_sm_addsub_pipe;
    import sm_arith_pkg::*;
    localparam int NW = NW_DEF;
    localparam int TW = 8;
    localparam int CW = 16;

    typedef struct {
        logic [NW:0]   sum;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clr = 1'b0;
    logic [CW-1:0] ovf_cnt;
    int n_chk = 0;
    int n_err = 0;
    exp_t q[$];
    logic [TW-1:0] got_tags[$];
    logic [CW-1:0] m_cnt = '0;
    logic [NW:0] last_sum;
    logic last_ovf;
    logic [TW-1:0] last_tag;
    logic acc;
    logic [TW-1:0] tag_ctr = 8'd10;

    sm_addsub_pipe_if #(.NUMWIDTH(NW), .TAG_W(TW)) io ();

    sm_addsub_pipe #(.NUMWIDTH(NW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (io),
        .cnt_clr (cnt_clr),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_op(input logic [NW:0] a, input logic [NW:0] b, input logic sub, input logic [TW-1:0] tag);
        exp_t e;
        longint va, vb, r, m;
        va = sign_of(a) ? -longint'(mag_of(a)) : longint'(mag_of(a));
        vb = sign_of(b) ? -longint'(mag_of(b)) : longint'(mag_of(b));
        r = sub ? va - vb : va + vb;
        m = (r < 0) ? -r : r;
        e.ovf = m > longint'(MAX_MAG);
`ifdef SM_SAT_EN
        if (e.ovf) m = longint'(MAX_MAG);
`else
        m = m % (longint'(MAX_MAG) + 1);
`endif
        e.sum = {(r < 0) && (m != 0), m[NW-1:0]};
        e.tag = tag;
        return e;
    endfunction

    task automatic step(input logic v, input logic [NW:0] a, input logic [NW:0] b, input logic s,
                        input logic [TW-1:0] t, input logic ordy, input logic clr, output logic accepted);
        exp_t e;
        logic cons;
        @(negedge clk);
        io.in_valid = v;
        io.in_a = a;
        io.in_b = b;
        io.in_sub = s;
        io.in_tag = t;
        io.out_ready = ordy;
        cnt_clr = clr;
        #1;
        chk("ovf_cnt", ovf_cnt, m_cnt);
        chk("in_ready", io.in_ready, (q.size() < 2) || ordy);
        cons = io.out_valid && ordy;
        if (io.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q[0];
                chk("out_sum", io.out_sum, e.sum);
                chk("out_ovf", io.out_ovf, e.ovf);
                chk("out_tag", io.out_tag, e.tag);
            end
        end
        if (cons && q.size() > 0) begin
            e = q.pop_front();
            last_sum = io.out_sum;
            last_ovf = io.out_ovf;
            last_tag = io.out_tag;
            got_tags.push_back(io.out_tag);
            if (clr) m_cnt = '0;
            else if (e.ovf && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end else if (clr) begin
            m_cnt = '0;
        end
        accepted = v && io.in_ready;
        if (accepted) q.push_back(ref_op(a, b, s, t));
    endtask

    task automatic idle(input logic ordy);
        logic a_;
        step(1'b0, '0, '0, 1'b0, '0, ordy, 1'b0, a_);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_cnt = '0;
        #1;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_in_ready", io.in_ready, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic op1(input string nm, input logic [NW:0] a, input logic [NW:0] b, input logic s,
                       input logic [NW:0] exp_sum, input logic exp_ovf);
        tag_ctr = tag_ctr + 1'b1;
        step(1'b1, a, b, s, tag_ctr, 1'b1, 1'b0, acc);
        chk({nm, "_acc"}, acc, 1);
        idle(1'b1);
        chk({nm, "_lat1"}, io.out_valid, 0);
        idle(1'b1);
        chk({nm, "_lat2"}, io.out_valid, 1);
        chk({nm, "_sum"}, last_sum, exp_sum);
        chk({nm, "_ovf"}, last_ovf, exp_ovf);
        chk({nm, "_tag"}, last_tag, tag_ctr);
    endtask

    function automatic logic [NW:0] rnd_opd();
        logic [NW:0] x;
        case ($urandom_range(0, 5))
            0: x = SM_ZERO;
            1: x = {1'b1, {NW{1'b0}}};
            2: x = {1'b0, MAX_MAG};
            3: x = {1'b1, MAX_MAG};
            default: x = (NW + 1)'($urandom);
        endcase
        return x;
    endfunction

    initial begin
        int t;
        int cyc;
        io.in_valid = 1'b0;
        io.in_a = '0;
        io.in_b = '0;
        io.in_sub = 1'b0;
        io.in_tag = '0;
        io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        op1("add", 17'h00005, 17'h00003, 1'b0, 17'h00008, 1'b0);
        op1("eqsub", 17'h00007, 17'h00007, 1'b1, 17'h00000, 1'b0);
        op1("negz", 17'h10007, 17'h00007, 1'b0, 17'h00000, 1'b0);
        op1("subneg", 17'h00003, 17'h0000A, 1'b1, 17'h10007, 1'b0);
        op1("nsubn", 17'h1000A, 17'h10003, 1'b1, 17'h10007, 1'b0);
`ifdef SM_SAT_EN
        op1("ovf", 17'h0FFFF, 17'h00001, 1'b0, 17'h0FFFF, 1'b1);
`else
        op1("ovf", 17'h0FFFF, 17'h00001, 1'b0, 17'h00000, 1'b1);
`endif
        idle(1'b1);
        chk("ovf_cnt_one", ovf_cnt, 1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, acc);
        idle(1'b1);
        chk("ovf_cnt_clr", ovf_cnt, 0);

        got_tags.delete();
        t = 1;
        cyc = 0;
        while (t <= 4 && cyc < 30) begin
            step(1'b1, 17'(t * 16 + 1), 17'(t), 1'b0, 8'(t), cyc >= 3, 1'b0, acc);
            if (cyc == 2) chk("stall_in_ready", io.in_ready, 0);
            if (acc) t++;
            cyc++;
        end
        chk("stall_all_accepted", t, 5);
        drain();
        chk("stall_count", got_tags.size(), 4);
        for (int i = 0; i < 4 && i < got_tags.size(); i++) chk("stall_order", got_tags[i], i + 1);

        step(1'b1, 17'h00001, 17'h00002, 1'b0, 8'hA1, 1'b0, 1'b0, acc);
        step(1'b1, 17'h0FFFF, 17'h0FFFF, 1'b0, 8'hA2, 1'b0, 1'b0, acc);
        do_reset();
        repeat (4) idle(1'b1);

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, rnd_opd(), rnd_opd(), 1'($urandom), 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, acc);
        end
        drain();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
Parametrised, 2-stage pipelined sign-magnitude adder/subtractor with valid/ready handshakes, a tag passthrough and an overflow event counter. It is the next-generation replacement for the combinational sign-magnitude adder in the neuron-update datapath (v/u state update, synaptic current accumulation). It accepts one operation per cycle and guarantees a canonical +0 result.

Parameters:
NUMWIDTH, 16, magnitude bits; operands/result are NUMWIDTH+1 bits {sign, magnitude}, sign=1 negative
TAG_W, 8, width of opaque tag (e.g. neuron index) carried alongside the operation
CNT_W, 16, width of saturating overflow counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid && in_ready
in_a  in  NUMWIDTH+1  operand a
in_b  in  NUMWIDTH+1  operand b
in_sub  in  1  0: a+b, 1: a-b
in_tag  in  TAG_W  passthrough tag
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid && out_ready
out_sum  out  NUMWIDTH+1  result {sign, magnitude}
out_ovf  out  1  magnitude overflow on this result
out_tag  out  TAG_W  tag of this result
ovf_cnt  out  CNT_W  count of overflowed results delivered
cnt_clr  in  1  clear ovf_cnt

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst). Reset clears s1_valid, s2_valid, out_sum, out_ovf, out_tag and ovf_cnt to 0. In-flight operations are dropped. in_ready is 1 in the cycle after reset.
- Arithmetic:
  - eff_sign_b = b.sign ^ in_sub; an input -0 is treated as +0.
  - Equal effective signs: mag = a.mag + b.mag (NUMWIDTH+1 bits), sign = a.sign; carry-out sets ovf.
  - Differing signs: larger magnitude minus smaller, sign of the larger; equal magnitudes give +0.
  - Any zero magnitude result forces sign=0 (no -0 output, ever).
- Stage 1 (s1): registers eff signs, the magnitude compare, the swapped (big, small) magnitudes, the tag and an op-kind bit (add/diff).
- Stage 2 (s2): registers the magnitude sum or difference, the overflow handling, the zero normalisation and the tag. Its registers drive the out_* ports directly.
- Pipeline control:
  - s2_load = !s2_valid || out_ready
  - s1_load = !s1_valid || s2_load
  - in_ready = s1_load (combinational from out_ready)
- Latency: 2 cycles from acceptance to out_valid with out_ready held high. Throughput is 1 per cycle. Accept and emit in the same cycle is legal.
- Backpressure: when out_ready is low, at most 2 operations are held. No loss, duplication or reordering. out_* stay stable while out_valid && !out_ready.
- ovf_cnt increments by 1 when a result with out_ovf=1 is consumed. It saturates at all-ones.
- cnt_clr: ovf_cnt <= 0 on the next edge. If cnt_clr coincides with an overflow consume, the clear wins and that event is not counted.

Optional Feature:
SM_SAT_EN
- Defined: on overflow the magnitude saturates to all-ones, the sign is kept and out_ovf=1.
- Undefined: the magnitude wraps (low NUMWIDTH bits of the sum), the sign is kept, out_ovf=1, and a zero wrapped result is normalised to +0.

Decomposition:
- Package sm_arith_pkg holds:
  - sign-bit index (NUMWIDTH)
  - magnitude slice helpers
  - the canonical zero constant
  - the op encoding (ADD=0, SUB=1)
  - the max-magnitude constant
- One sub-module, sm_mag_order: combinational compare/swap. Takes two magnitudes and the two effective signs; outputs big, small, result sign and is_add. It is instantiated in stage 1.

Test Plan:
- a=0x00005, b=0x00003, sub=0, out_ready=1 -> 2 cycles later out_sum=0x00008, out_ovf=0, tag matches.
- a=0x00007, b=0x00007, sub=1 -> 0x00000; a=0x10007, b=0x00007, sub=0 -> 0x00000 (never 0x10000).
- a=0x00003, b=0x0000A, sub=1 -> 0x10007; a=0x1000A, b=0x10003, sub=1 -> 0x10007.
- a=0x0FFFF, b=0x00001, sub=0 -> out_ovf=1; with SM_SAT_EN out_sum=0x0FFFF, without it 0x00000; ovf_cnt=1 after consume; then cnt_clr -> 0.
- Back-to-back tags 1..4, out_ready low for 3 cycles -> in_ready low after 2 held; results delivered in order 1..4, values intact, outputs stable while stalled.
- Two ops in flight, rst high 1 cycle -> next cycle out_valid=0, ovf_cnt=0, in_ready=1; no stale result emitted.
